// File: rtl/dcache_port_arbiter.sv
// D-cache request-port arbiter between the LSQ load path and the retired-store drain.
// Holds the winning request until accepted and returns the tag-matched load response.
module dcache_port_arbiter #(
   parameter int ADDR_W       = 29,
   parameter int DATA_W       = 64,
   parameter int TAG_W        = 3,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ld_req_valid,
   input  logic [ADDR_W-1:0] ld_req_addr,
   input  logic [1:0]        ld_req_size,
   output logic              ld_req_ready,
   input  logic              st_req_valid,
   input  logic [ADDR_W-1:0] st_req_addr,
   input  logic [1:0]        st_req_size,
   input  logic [DATA_W-1:0] st_req_data,
   output logic              st_req_ready,
   input  logic              sq_full,
   input  logic              flush,
   output logic              dc_req_valid,
   output logic              dc_req_is_st,
   output logic [ADDR_W-1:0] dc_req_addr,
   output logic [1:0]        dc_req_size,
   output logic [DATA_W-1:0] dc_req_data,
   output logic [TAG_W-1:0]  dc_req_tag,
   input  logic              dc_req_accept,
   input  logic              dc_rsp_valid,
   input  logic [TAG_W-1:0]  dc_rsp_tag,
   input  logic [DATA_W-1:0] dc_rsp_data,
   output logic              ld_rsp_valid,
   output logic [DATA_W-1:0] ld_rsp_data
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [2:0] {IDLE, ST_REQ, LD_REQ, LD_WAIT, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  starve_cnt;
   logic [TAG_W-1:0]  tag_ctr;
   logic [TAG_W-1:0]  ld_tag;
   logic [ADDR_W-1:0] ld_addr;
   logic [1:0]        ld_size;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;

   logic st_win, ld_win, rsp_hit;

   // A store bypasses the load when the SQ is full, it has starved long enough, or no load competes.
   assign st_win  = st_req_valid && (sq_full || (starve_cnt >= LIMIT) || !ld_req_valid);
   assign ld_win  = ld_req_valid && !st_win;
   assign rsp_hit = dc_rsp_valid && (dc_rsp_tag == ld_tag);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         starve_cnt  <= '0;
         tag_ctr     <= '0;
         ld_tag      <= '0;
         ld_addr     <= '0;
         ld_size     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state <= state_nxt;

         if (state == IDLE && st_win)
            starve_cnt <= '0;
         else if (state == IDLE && ld_win && st_req_valid && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 1'b1;

         if (state == IDLE && ld_win) begin
            ld_addr <= ld_req_addr;
            ld_size <= ld_req_size;
            ld_tag  <= tag_ctr;
         end

         // The tag is consumed on accept even if a flush squashes the load in that same cycle.
         if (state == LD_REQ && dc_req_accept)
            tag_ctr <= tag_ctr + 1'b1;

         rsp_valid_q <= (state == LD_WAIT) && rsp_hit && !flush;
         rsp_data_q  <= ((state == LD_WAIT) && rsp_hit && !flush) ? dc_rsp_data : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (st_win)             state_nxt = ST_REQ;
                  else if (ld_req_valid)  state_nxt = LD_REQ;
         ST_REQ:  if (dc_req_accept)      state_nxt = IDLE;
         LD_REQ:  if (dc_req_accept)      state_nxt = flush ? DRAIN : LD_WAIT;
                  else if (flush)         state_nxt = IDLE;
         LD_WAIT: if (flush)              state_nxt = DRAIN;
                  else if (rsp_hit)       state_nxt = IDLE;
         DRAIN:   if (rsp_hit)            state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      ld_req_ready = 1'b0;
      st_req_ready = 1'b0;
      dc_req_valid = 1'b0;
      dc_req_is_st = 1'b0;
      dc_req_addr  = '0;
      dc_req_size  = '0;
      dc_req_data  = '0;
      dc_req_tag   = '0;
      ld_rsp_valid = 1'b0;
      ld_rsp_data  = '0;
      // Outputs are forced quiet while reset is held so a pending request disappears immediately.
      if (!reset) begin
         ld_rsp_valid = rsp_valid_q;
         ld_rsp_data  = rsp_data_q;
         case (state)
            IDLE: ld_req_ready = ld_win;
            ST_REQ: begin
               dc_req_valid = 1'b1;
               dc_req_is_st = 1'b1;
               dc_req_addr  = st_req_addr;
               dc_req_size  = st_req_size;
               dc_req_data  = st_req_data;
               st_req_ready = dc_req_accept;
            end
            LD_REQ: begin
               dc_req_valid = 1'b1;
               dc_req_addr  = ld_addr;
               dc_req_size  = ld_size;
               dc_req_tag   = ld_tag;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: a per-cycle vector table for load, starvation and
// sq_full arbitration, then hand sequences for flush/drain, store back-pressure and reset.
module tb_dcache_port_arbiter;

   localparam logic [28:0] LD_A   = 29'h100;
   localparam logic [28:0] ST_A   = 29'h2A0;
   localparam logic [28:0] JUNK_A = 29'h1FFF_FFFF;
   localparam logic [63:0] ST_D   = 64'hCAFE_F00D_1234_5678;
   localparam logic [1:0]  LD_SZ  = 2'd3;
   localparam logic [1:0]  ST_SZ  = 2'd2;

   logic        clock;
   logic        reset;
   logic        ld_req_valid;
   logic [28:0] ld_req_addr;
   logic [1:0]  ld_req_size;
   logic        ld_req_ready;
   logic        st_req_valid;
   logic [28:0] st_req_addr;
   logic [1:0]  st_req_size;
   logic [63:0] st_req_data;
   logic        st_req_ready;
   logic        sq_full;
   logic        flush;
   logic        dc_req_valid;
   logic        dc_req_is_st;
   logic [28:0] dc_req_addr;
   logic [1:0]  dc_req_size;
   logic [63:0] dc_req_data;
   logic [2:0]  dc_req_tag;
   logic        dc_req_accept;
   logic        dc_rsp_valid;
   logic [2:0]  dc_rsp_tag;
   logic [63:0] dc_rsp_data;
   logic        ld_rsp_valid;
   logic [63:0] ld_rsp_data;

   int n_vec  = 0;
   int n_miss = 0;

   // Inputs for one cycle, then the outputs expected before that cycle's rising edge.
   typedef struct {
      logic        rst;
      logic        ldv;
      logic        stv;
      logic        sqf;
      logic        fl;
      logic        acc;
      logic        rspv;
      logic [2:0]  rtag;
      logic [63:0] rdata;
      logic        e_ldr;
      logic        e_str;
      logic        e_dcv;
      logic        e_isst;
      logic [2:0]  e_tag;
      logic        e_rspv;
      logic [63:0] e_rdata;
   } vec_t;

   vec_t tbl[$];

   dcache_port_arbiter #(
      .ADDR_W(29), .DATA_W(64), .TAG_W(3), .STARVE_LIMIT(4)
   ) dut (
      .clock(clock), .reset(reset),
      .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_size(ld_req_size),
      .ld_req_ready(ld_req_ready),
      .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_size(st_req_size),
      .st_req_data(st_req_data), .st_req_ready(st_req_ready),
      .sq_full(sq_full), .flush(flush),
      .dc_req_valid(dc_req_valid), .dc_req_is_st(dc_req_is_st), .dc_req_addr(dc_req_addr),
      .dc_req_size(dc_req_size), .dc_req_data(dc_req_data), .dc_req_tag(dc_req_tag),
      .dc_req_accept(dc_req_accept),
      .dc_rsp_valid(dc_rsp_valid), .dc_rsp_tag(dc_rsp_tag), .dc_rsp_data(dc_rsp_data),
      .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs (unused request fields get junk), compare outputs, advance a cycle.
   task automatic step(input string nm, input vec_t v);
      logic [28:0] e_addr;
      logic [1:0]  e_size;
      logic [63:0] e_data;
      reset         = v.rst;
      ld_req_valid  = v.ldv;
      ld_req_addr   = v.ldv ? LD_A : JUNK_A;
      ld_req_size   = v.ldv ? LD_SZ : 2'd0;
      st_req_valid  = v.stv;
      st_req_addr   = v.stv ? ST_A : JUNK_A;
      st_req_size   = v.stv ? ST_SZ : 2'd0;
      st_req_data   = v.stv ? ST_D : 64'h0;
      sq_full       = v.sqf;
      flush         = v.fl;
      dc_req_accept = v.acc;
      dc_rsp_valid  = v.rspv;
      dc_rsp_tag    = v.rtag;
      dc_rsp_data   = v.rdata;
      e_addr = v.e_dcv ? (v.e_isst ? ST_A : LD_A) : 29'h0;
      e_size = v.e_dcv ? (v.e_isst ? ST_SZ : LD_SZ) : 2'd0;
      e_data = (v.e_dcv && v.e_isst) ? ST_D : 64'h0;
      #1;
      check({nm, " ld_req_ready"}, 64'(ld_req_ready), 64'(v.e_ldr));
      check({nm, " st_req_ready"}, 64'(st_req_ready), 64'(v.e_str));
      check({nm, " dc_req_valid"}, 64'(dc_req_valid), 64'(v.e_dcv));
      check({nm, " dc_req_is_st"}, 64'(dc_req_is_st), 64'(v.e_isst));
      check({nm, " dc_req_addr"},  64'(dc_req_addr),  64'(e_addr));
      check({nm, " dc_req_size"},  64'(dc_req_size),  64'(e_size));
      check({nm, " dc_req_data"},  dc_req_data,       e_data);
      check({nm, " dc_req_tag"},   64'(dc_req_tag),   64'(v.e_tag));
      check({nm, " ld_rsp_valid"}, 64'(ld_rsp_valid), 64'(v.e_rspv));
      check({nm, " ld_rsp_data"},  ld_rsp_data,       v.e_rdata);
      @(negedge clock);
   endtask

   // Complete load: grant, accept with the given tag, response, registered return.
   task automatic do_load(input string nm, input logic [2:0] tag, input logic [63:0] data);
      step({nm, " grant"}, vec_t'{0,1,0,0,0,0,0,0,0,     1,0,0,0,0,  0,0});
      step({nm, " acc"},   vec_t'{0,0,0,0,0,1,0,0,0,     0,0,1,0,tag,0,0});
      step({nm, " rsp"},   vec_t'{0,0,0,0,0,0,1,tag,data, 0,0,0,0,0,  0,0});
      step({nm, " ret"},   vec_t'{0,0,0,0,0,0,0,0,0,     0,0,0,0,0,  1,data});
   endtask

   initial begin
      step_idle_init();

      // rst ldv stv sqf fl acc rspv rtag rdata | ldr str dcv isst tag rspv rdata
      // Reset held with a load offered: everything quiet.
      tbl.push_back(vec_t'{1,1,0,0,0,0,0,0,0,         0,0,0,0,0,0,0});
      // Load only: grant, valid next cycle, accept, stray tag ignored, response, return.
      tbl.push_back(vec_t'{0,1,0,0,0,0,0,0,0,         1,0,0,0,0,0,0});
      tbl.push_back(vec_t'{0,0,0,0,0,0,0,0,0,         0,0,1,0,0,0,0});
      tbl.push_back(vec_t'{0,0,0,0,0,1,0,0,0,         0,0,1,0,0,0,0});
      tbl.push_back(vec_t'{0,0,0,0,0,0,1,5,64'hBAD,   0,0,0,0,0,0,0});
      tbl.push_back(vec_t'{0,0,0,0,0,0,1,0,64'hDEAD,  0,0,0,0,0,0,0});
      tbl.push_back(vec_t'{0,0,0,0,0,0,0,0,0,         0,0,0,0,0,1,64'hDEAD});
      // Load and store both valid: four load wins (tags 1..4), then the starved store.
      tbl.push_back(vec_t'{0,1,1,0,0,0,0,0,0,         1,0,0,0,0,0,0});
      tbl.push_back(vec_t'{0,1,1,0,0,1,0,0,0,         0,0,1,0,1,0,0});
      tbl.push_back(vec_t'{0,1,1,0,0,0,1,1,64'h11,    0,0,0,0,0,0,0});
      tbl.push_back(vec_t'{0,1,1,0,0,0,0,0,0,         1,0,0,0,0,1,64'h11});
      tbl.push_back(vec_t'{0,1,1,0,0,1,0,0,0,         0,0,1,0,2,0,0});
      tbl.push_back(vec_t'{0,1,1,0,0,0,1,2,64'h22,    0,0,0,0,0,0,0});
      tbl.push_back(vec_t'{0,1,1,0,0,0,0,0,0,         1,0,0,0,0,1,64'h22});
      tbl.push_back(vec_t'{0,1,1,0,0,1,0,0,0,         0,0,1,0,3,0,0});
      tbl.push_back(vec_t'{0,1,1,0,0,0,1,3,64'h33,    0,0,0,0,0,0,0});
      tbl.push_back(vec_t'{0,1,1,0,0,0,0,0,0,         1,0,0,0,0,1,64'h33});
      tbl.push_back(vec_t'{0,1,1,0,0,1,0,0,0,         0,0,1,0,4,0,0});
      tbl.push_back(vec_t'{0,1,1,0,0,0,1,4,64'h44,    0,0,0,0,0,0,0});
      tbl.push_back(vec_t'{0,1,1,0,0,0,0,0,0,         0,0,0,0,0,1,64'h44});
      tbl.push_back(vec_t'{0,1,1,0,0,1,0,0,0,         0,1,1,1,0,0,0});
      // Starvation count cleared: the load wins again (tag 5).
      tbl.push_back(vec_t'{0,1,1,0,0,0,0,0,0,         1,0,0,0,0,0,0});
      tbl.push_back(vec_t'{0,1,1,0,0,1,0,0,0,         0,0,1,0,5,0,0});
      tbl.push_back(vec_t'{0,1,1,0,0,0,1,5,64'h55,    0,0,0,0,0,0,0});
      // sq_full forces the store ahead of a valid load.
      tbl.push_back(vec_t'{0,1,1,1,0,0,0,0,0,         0,0,0,0,0,1,64'h55});
      tbl.push_back(vec_t'{0,1,1,1,0,1,0,0,0,         0,1,1,1,0,0,0});
      tbl.push_back(vec_t'{0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0});

      foreach (tbl[i]) step($sformatf("v%0d", i), tbl[i]);

      // Tag counter wraps 6,7,0,1.
      do_load("wrap6", 3'd6, 64'h66);
      do_load("wrap7", 3'd7, 64'h77);
      do_load("wrap0", 3'd0, 64'h100);
      do_load("wrap1", 3'd1, 64'h101);

      // Flush in LD_WAIT on tag 2; response 5 cycles later is drained, then regrant.
      step("fl grant", vec_t'{0,1,0,0,0,0,0,0,0,        1,0,0,0,0,0,0});
      step("fl acc",   vec_t'{0,0,0,0,0,1,0,0,0,        0,0,1,0,2,0,0});
      step("fl flush", vec_t'{0,0,0,0,1,0,0,0,0,        0,0,0,0,0,0,0});
      step("drain1",   vec_t'{0,1,0,0,0,0,0,0,0,        0,0,0,0,0,0,0});
      step("drain2",   vec_t'{0,1,0,0,0,0,1,3,64'hBAD,  0,0,0,0,0,0,0});
      step("drain3",   vec_t'{0,1,0,0,0,0,0,0,0,        0,0,0,0,0,0,0});
      step("drain4",   vec_t'{0,1,0,0,0,0,0,0,0,        0,0,0,0,0,0,0});
      step("drain rsp",vec_t'{0,1,0,0,0,0,1,2,64'h2222, 0,0,0,0,0,0,0});
      step("regrant",  vec_t'{0,1,0,0,0,0,0,0,0,        1,0,0,0,0,0,0});
      step("re acc",   vec_t'{0,0,0,0,0,1,0,0,0,        0,0,1,0,3,0,0});
      step("re rsp",   vec_t'{0,0,0,0,0,0,1,3,64'h3333, 0,0,0,0,0,0,0});
      step("re ret",   vec_t'{0,1,0,0,0,0,0,0,0,        1,0,0,0,0,1,64'h3333});
      // Flush before accept drops the request; tag 4 is reused by the next grant.
      step("pre flush",vec_t'{0,0,0,0,1,0,0,0,0,        0,0,1,0,4,0,0});
      step("pre regr", vec_t'{0,1,0,0,0,0,0,0,0,        1,0,0,0,0,0,0});
      // Flush coincident with accept goes to DRAIN; the tag-4 response is swallowed.
      step("acc flush",vec_t'{0,0,0,0,1,1,0,0,0,        0,0,1,0,4,0,0});
      step("acc drain",vec_t'{0,1,0,0,0,0,1,4,64'h4444, 0,0,0,0,0,0,0});
      step("acc quiet",vec_t'{0,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0});

      // Cache stalls a store for 6 cycles (one with flush): request stable, no ready.
      step("st grant", vec_t'{0,0,1,0,0,0,0,0,0,        0,0,0,0,0,0,0});
      for (int i = 0; i < 6; i++)
         step($sformatf("st stall%0d", i), vec_t'{0,0,1,0,(i == 2),0,0,0,0, 0,0,1,1,0,0,0});
      step("st acc",   vec_t'{0,0,1,0,0,1,0,0,0,        0,1,1,1,0,0,0});
      step("st after", vec_t'{0,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0});

      // Reset during LD_WAIT (tag 5) with a matching response in the reset cycle.
      step("rs grant", vec_t'{0,1,0,0,0,0,0,0,0,        1,0,0,0,0,0,0});
      step("rs acc",   vec_t'{0,0,0,0,0,1,0,0,0,        0,0,1,0,5,0,0});
      step("rs wait",  vec_t'{0,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0});
      step("rs reset", vec_t'{1,1,0,0,0,0,1,5,64'h5555, 0,0,0,0,0,0,0});
      step("rs after", vec_t'{0,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0});
      step("rs late",  vec_t'{0,0,0,0,0,0,1,0,64'hBAD,  0,0,0,0,0,0,0});
      step("rs regr",  vec_t'{0,1,0,0,0,0,0,0,0,        1,0,0,0,0,0,0});
      step("rs tag0",  vec_t'{0,0,0,0,0,1,0,0,0,        0,0,1,0,0,0,0});
      step("rs idle",  vec_t'{0,0,0,0,0,0,0,0,0,        0,0,0,0,0,0,0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // Hold reset with quiet inputs from time 0 until the first falling edge.
   task automatic step_idle_init();
      reset         = 1'b1;
      ld_req_valid  = 1'b0;
      ld_req_addr   = '0;
      ld_req_size   = '0;
      st_req_valid  = 1'b0;
      st_req_addr   = '0;
      st_req_size   = '0;
      st_req_data   = '0;
      sq_full       = 1'b0;
      flush         = 1'b0;
      dc_req_accept = 1'b0;
      dc_rsp_valid  = 1'b0;
      dc_rsp_tag    = '0;
      dc_rsp_data   = '0;
      @(negedge clock);
   endtask

endmodule
